// File: rtl/coeff_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : coeff_mem_ctrl
// Brief  : Ping-pong coefficient SRAM controller; engine bursts from the active
//          bank, host accesses the shadow bank, banks swap on commit.
// Rev    : 1.0
// ============================================================================
module coeff_mem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [6:0]  h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ack,
  output logic [31:0] h_rdata,
  input  logic        h_commit,
  output logic        commit_pending,
  output logic        active_bank,
  input  logic        e_start,
  input  logic [6:0]  e_base,
  input  logic [7:0]  e_len,
  output logic        e_busy,
  output logic        e_valid,
  output logic [31:0] e_data,
  output logic [6:0]  e_idx,
  output logic        e_last,
  output logic        sram_wen,
  output logic        sram_ren,
  output logic [7:0]  sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] C_RUN_MAX = 4'd8;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_active_bank;
  logic        r_commit_pending;
  logic [3:0]  r_run_cnt;
  logic [6:0]  r_rd_cnt;
  logic [6:0]  r_last_idx;
  logic [6:0]  r_base;
  logic        r_h_ack;
  logic        r_h_rd;
  logic        r_e_valid;
  logic        r_e_last;
  logic [6:0]  r_e_idx;

  logic        w_host_pend;
  logic        w_host_grant;
  logic        w_eng_rd;
  logic        w_start_ok;
  logic        w_swap;
  logic        w_last_rd;
  logic [6:0]  w_last_idx;
  logic [6:0]  w_eng_off;

  // rst_n gates the host path so every SRAM strobe is low while reset is held
  assign w_host_pend = rst_n & h_req & ~r_h_ack;
  assign w_start_ok  = (r_state == ST_IDLE) & e_start & (e_len != 8'd0);
  assign w_last_idx  = e_len[7] ? 7'd127 : (e_len[6:0] - 7'd1);
  assign w_last_rd   = (r_rd_cnt == r_last_idx);
  assign w_eng_off   = r_base + r_rd_cnt;
  assign w_swap      = (r_state == ST_IDLE) & r_commit_pending & ~w_host_grant;

  always_comb begin
    w_host_grant = 1'b0;
    w_eng_rd     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DRAIN: w_host_grant = w_host_pend;
      ST_BURST: begin
        w_host_grant = w_host_pend & (r_run_cnt == C_RUN_MAX);
        w_eng_rd     = ~w_host_grant;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_BURST;
      ST_BURST: if (w_eng_rd && w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_bank    <= 1'b0;
      r_commit_pending <= 1'b0;
      r_run_cnt        <= 4'd0;
      r_rd_cnt         <= 7'd0;
      r_last_idx       <= 7'd0;
      r_base           <= 7'd0;
      r_h_ack          <= 1'b0;
      r_h_rd           <= 1'b0;
      r_e_valid        <= 1'b0;
      r_e_last         <= 1'b0;
      r_e_idx          <= 7'd0;
    end else begin
      r_h_ack   <= w_host_grant;
      r_h_rd    <= w_host_grant & ~h_we;
      r_e_valid <= w_eng_rd;
      r_e_last  <= w_eng_rd & w_last_rd;
      r_e_idx   <= w_eng_rd ? r_rd_cnt : 7'd0;

      if (w_start_ok) begin
        r_base     <= e_base;
        r_last_idx <= w_last_idx;
        r_rd_cnt   <= 7'd0;
      end else if (w_eng_rd) begin
        r_rd_cnt <= r_rd_cnt + 7'd1;
      end

      // Saturates at the fairness threshold until the host takes a slot
      if (w_host_grant || (r_state != ST_BURST))
        r_run_cnt <= 4'd0;
      else if (r_run_cnt != C_RUN_MAX)
        r_run_cnt <= r_run_cnt + 4'd1;

      if (w_swap) begin
        r_active_bank    <= ~r_active_bank;
        r_commit_pending <= 1'b0;
      end else if (h_commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  assign sram_wen   = w_host_grant & h_we;
  assign sram_ren   = (w_host_grant & ~h_we) | w_eng_rd;
  assign sram_addr  = w_eng_rd     ? {r_active_bank, w_eng_off} :
                      w_host_grant ? {~r_active_bank, h_addr}   : 8'd0;
  assign sram_wdata = sram_wen ? h_wdata : 32'd0;

  assign h_ack          = r_h_ack;
  assign h_rdata        = r_h_rd ? sram_rdata : 32'd0;
  assign commit_pending = r_commit_pending;
  assign active_bank    = r_active_bank;
  assign e_busy         = (r_state != ST_IDLE);
  assign e_valid        = r_e_valid;
  assign e_data         = r_e_valid ? sram_rdata : 32'd0;
  assign e_idx          = r_e_idx;
  assign e_last         = r_e_last;

endmodule
`default_nettype wire

// File: tb/tb_coeff_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_coeff_mem_ctrl
// Brief  : Randomized self-checking bench for coeff_mem_ctrl with SRAM model.
// Rev    : 1.0
// ============================================================================
module tb_coeff_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        h_req, h_we, h_commit, e_start;
  logic [6:0]  h_addr, e_base;
  logic [31:0] h_wdata;
  logic [7:0]  e_len;
  logic        h_ack, commit_pending, active_bank, e_busy, e_valid, e_last;
  logic        sram_wen, sram_ren;
  logic [31:0] h_rdata, e_data, sram_wdata, sram_rdata;
  logic [6:0]  e_idx;
  logic [7:0]  sram_addr;

  always #5 clk = ~clk;

  coeff_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .h_commit(h_commit), .commit_pending(commit_pending), .active_bank(active_bank),
    .e_start(e_start), .e_base(e_base), .e_len(e_len),
    .e_busy(e_busy), .e_valid(e_valid), .e_data(e_data), .e_idx(e_idx), .e_last(e_last),
    .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [31:0] sram_mem [256];
  logic [31:0] exp_mem  [256];
  logic        exp_bank;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_conflict = 0;

  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= sram_mem[sram_addr];
  end

  always @(negedge clk) if (sram_wen && sram_ren) n_conflict++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic host_acc(input logic we, input logic [6:0] addr, input logic [31:0] data);
    logic seen, done;
    seen = 1'b0;
    done = 1'b0;
    @(posedge clk); #1;
    h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = data;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!seen && (sram_wen || sram_ren)) begin
        seen = 1'b1;
        check("host_addr", 64'(sram_addr), 64'({~exp_bank, addr}));
        check("host_we", 64'(sram_wen), 64'(we));
      end
      if (h_ack) begin
        done = 1'b1;
        if (!we) check("host_rdata", 64'(h_rdata), 64'(exp_mem[{~exp_bank, addr}]));
        break;
      end
      @(posedge clk); #1;
    end
    check("host_ack", 64'(done), 64'd1);
    if (we) exp_mem[{~exp_bank, addr}] = data;
    @(posedge clk); #1;
    h_req = 1'b0;
  endtask

  task automatic do_commit();
    @(posedge clk); #1; h_commit = 1'b1;
    @(posedge clk); #1; h_commit = 1'b0;
    @(negedge clk);
    check("commit_pend", 64'(commit_pending), 64'd1);
    check("commit_bank_old", 64'(active_bank), 64'(exp_bank));
    @(posedge clk); #1;
    @(negedge clk);
    exp_bank = ~exp_bank;
    check("commit_bank_new", 64'(active_bank), 64'(exp_bank));
    check("commit_clear", 64'(commit_pending), 64'd0);
  endtask

  // mode: 0 plain, 1 host contending, 2 commit mid-burst, 3 restart ignored, 4 swap with start
  task automatic run_burst(input logic [6:0] base, input logic [7:0] len, input int mode);
    int eff, steals, busy_cnt, nval, bank_err, pend_err;
    logic [6:0] haddr;
    logic [7:0] a;
    eff      = (len > 8'd128) ? 128 : int'(len);
    steals   = (mode == 1 && eff > 0) ? (eff - 1) / 8 : 0;
    busy_cnt = 0; nval = 0; bank_err = 0; pend_err = 0;
    haddr    = 7'($urandom);
    if (mode == 4) begin
      @(posedge clk); #1; h_commit = 1'b1;
    end
    @(posedge clk); #1;
    h_commit = 1'b0;
    e_start = 1'b1; e_base = base; e_len = len;
    if (mode == 1) begin h_req = 1'b1; h_we = 1'b0; h_addr = haddr; end
    if (mode == 4) exp_bank = ~exp_bank;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      e_start = (mode == 3 && c == 3);
      if (e_start) begin e_base = base + 7'd7; e_len = 8'd5; end
      h_commit = (mode == 2 && c == 5);
      @(negedge clk);
      if (e_busy) busy_cnt++;
      if (active_bank !== exp_bank) bank_err++;
      if (mode == 2 && c >= 6 && e_busy && !commit_pending) pend_err++;
      if (e_valid) begin
        a = {exp_bank, base + 7'(nval)};
        check("e_data", 64'(e_data), 64'(exp_mem[a]));
        check("e_idx_last", 64'({e_last, e_idx}), 64'({nval == eff - 1, 7'(nval)}));
        nval++;
      end
      if (mode == 1 && h_ack)
        check("steal_rdata", 64'(h_rdata), 64'(exp_mem[{~exp_bank, haddr}]));
      if (!e_busy) break;
    end
    h_commit = 1'b0;
    check("e_count", 64'(nval), 64'(eff));
    check("busy_cycles", 64'(busy_cnt), 64'((eff == 0) ? 0 : eff + 1 + steals));
    check("bank_hold", 64'(bank_err), 64'd0);
    if (mode == 2) begin
      check("pend_hold", 64'(pend_err), 64'd0);
      check("pend_at_idle", 64'(commit_pending), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      exp_bank = ~exp_bank;
      check("swap_bank", 64'(active_bank), 64'(exp_bank));
      check("swap_clear", 64'(commit_pending), 64'd0);
    end
    @(posedge clk); #1;
    h_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int nv, m, mode;
    logic [7:0] len;
    logic [31:0] v;
    rst_n = 1'b0; h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    h_commit = 1'b0; e_start = 1'b0; e_base = '0; e_len = '0;
    exp_bank = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      exp_mem[i]  = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 64'({h_ack, e_busy, e_valid, e_last, sram_wen, sram_ren,
                          commit_pending, active_bank}), 64'd0);
    check("rst_data", {h_rdata, e_data}, 64'd0);
    check("rst_addr", 64'({sram_addr, sram_wdata, e_idx}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 128; k++) host_acc(1'b1, 7'(k), 32'hA5A5_0000 + 32'(k));
    do_commit();
    check("bank_after_commit", 64'(active_bank), 64'd1);
    run_burst(7'd0, 8'd128, 0);

    for (int k = 0; k < 6; k++) host_acc(1'b1, 7'($urandom), $urandom);
    for (int k = 0; k < 4; k++) host_acc(1'b0, 7'($urandom), 32'd0);
    run_burst(7'd120, 8'd16, 0);
    run_burst(7'($urandom), 8'd128, 1);
    run_burst(7'($urandom), 8'd100, 2);
    run_burst(7'd5, 8'd0, 0);
    run_burst(7'($urandom), 8'd200, 0);
    run_burst(7'd60, 8'd20, 3);
    host_acc(1'b1, 7'd9, 32'hDEAD_BEEF);
    run_burst(7'd0, 8'd24, 4);

    for (int it = 0; it < 8; it++) begin
      host_acc(1'b1, 7'($urandom), $urandom);
      host_acc(1'b0, 7'($urandom), 32'd0);
      len = 8'($urandom_range(0, 255));
      m = $urandom_range(0, 2);
      mode = (m == 2) ? ((len >= 8'd6) ? 3 : 0) : m;
      run_burst(7'($urandom), len, mode);
    end

    if (exp_bank == 1'b0) do_commit();
    @(posedge clk); #1;
    e_start = 1'b1; e_base = 7'd3; e_len = 8'd64;
    @(posedge clk); #1;
    e_start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 64'({h_ack, e_busy, e_valid, e_last, sram_wen, sram_ren,
                              commit_pending, active_bank}), 64'd0);
    check("mid_rst_data", {h_rdata, e_data}, 64'd0);
    check("mid_rst_addr", 64'({sram_addr, sram_wdata, e_idx}), 64'd0);
    exp_bank = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (e_valid || e_busy) nv++;
    end
    check("post_rst_quiet", 64'(nv), 64'd0);
    run_burst(7'd100, 8'd40, 0);

    check("wen_ren_excl", 64'(n_conflict), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coeff_mem_ctrl.md
# coeff_mem_ctrl

Controller and arbiter for the 256×32 coefficient SRAM. Splits the SRAM into two 128-word banks (ping-pong). The filter engine streams coefficients from the active bank. The host register interface reads and writes the shadow bank, and the banks swap atomically on a committed update. Sits between the host register block, the FIR engine and the coefficient SRAM, and owns every SRAM control pin.

## Interface
- No parameters; geometry fixed at 2 banks × 128 words × 32 bits.
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- h_req  in  1  host access request; held high until h_ack.
- h_we  in  1  host write (1) / read (0); stable while h_req.
- h_addr  in  7  host word offset within the shadow bank.
- h_wdata  in  32  host write data.
- h_ack  out  1  one-cycle access-complete pulse.
- h_rdata  out  32  read data, valid while h_ack and h_we=0.
- h_commit  in  1  pulse: request bank swap.
- commit_pending  out  1  swap requested, not yet applied.
- active_bank  out  1  bank currently read by the engine.
- e_start  in  1  pulse: start a coefficient burst.
- e_base  in  7  first word offset in the active bank.
- e_len  in  8  burst length in words; valid range 1..128.
- e_busy  out  1  burst in progress.
- e_valid  out  1  e_data valid this cycle.
- e_data  out  32  coefficient word.
- e_idx  out  7  burst-relative index of e_data, 0..len-1.
- e_last  out  1  qualifies the final e_valid of a burst.
- sram_wen, sram_ren  out  1  SRAM write and read strobes.
- sram_addr  out  8  {bank, offset}.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, registered one cycle after sram_ren.

## Operation
- At most one SRAM operation per cycle. sram_wen and sram_ren are never both high.
- FSM states:
  - IDLE → BURST on an accepted e_start.
  - BURST → DRAIN after the last read is issued.
  - DRAIN → IDLE after the last e_valid.
- e_start handling:
  - Accepted only in IDLE.
  - e_len=0: ignored; e_busy stays low.
  - e_len>128: clamped to 128.
  - e_start outside IDLE: ignored.
- Burst read address: {active_bank, (e_base + i) mod 128}, with i = 0..len-1. Offsets wrap 127 → 0.
- Host accesses always target {~active_bank, h_addr}.
- Arbitration:
  - In IDLE, a pending h_req wins the slot.
  - In BURST, the engine has priority.
  - A run counter counts consecutive engine slots. When it reaches 8 and h_req is pending, the next slot goes to the host and the engine read index stalls one cycle.
  - The run counter clears on a host slot and on burst end.
  - The host is never starved for more than 8 cycles.
- h_req is ignored in the cycle h_ack is high. Back-to-back host accesses therefore take at least 2 cycles each.
- Commit:
  - h_commit sets commit_pending.
  - The swap toggles active_bank in the first cycle the FSM is IDLE with no host access granted that cycle.
  - commit_pending clears in the same cycle as the swap.
  - h_commit while commit_pending is already high has no further effect.
  - h_commit during BURST is deferred until the burst ends. The bank never changes mid-burst.
- Simultaneous swap and e_start in IDLE: the swap applies first, and the burst reads the new active bank.
- Host writes issued while commit_pending is high still go to the pre-swap shadow bank.

## Timing
- Reset values:
  - h_ack, e_busy, e_valid, e_last, sram_wen, sram_ren, commit_pending: 0.
  - active_bank: 0.
  - h_rdata, e_data, sram_addr, sram_wdata: 0.
  - FSM: IDLE.
  - Run counter: 0.
- Reset mid-burst aborts the burst immediately. No further e_valid is produced.
- Engine path:
  - e_start accepted at cycle t: e_busy=1 from t+1; first sram_ren at t+1.
  - A read issued at cycle c produces e_valid/e_data/e_idx at c+1. e_data = sram_rdata, passed through.
  - e_last accompanies idx len-1.
  - e_busy falls the cycle after e_last.
- Host path: grant at cycle g drives sram_wen or sram_ren at g. h_ack (and h_rdata for reads) follows at g+1.
- Commit latency: 1 cycle when idle. The swap cycle is the first eligible cycle after h_commit is registered.
- Uninterrupted burst: len+1 cycles from first read to e_busy low. Each host slot stolen adds 1 cycle.

## Test plan
- Reset, then host-write 0xA5A5_0000+k to offsets 0..127, commit, burst e_base=0 e_len=128 → active_bank=1 and e_data[k]=0xA5A5_0000+k. No e_valid gaps; e_last at idx 127. Host writes drive sram_addr[7]=1 before the swap; the burst reads with sram_addr[7]=1 after it.
- Wrap: e_base=120, e_len=16 → reads offsets 120..127, then 0..7; e_idx 0..15.
- Fairness: h_req held high during a 128-word burst → host granted after exactly 8 engine slots each time. Burst length becomes 128+k cycles; data order is unchanged.
- Commit during burst → active_bank is unchanged until e_busy falls, then toggles one cycle later. commit_pending is high throughout.
- e_len=0 → no busy. e_len=200 → exactly 128 e_valid. e_start while busy → ignored.
- Assert rst_n mid-burst → all outputs 0 asynchronously and active_bank=0. A new burst after reset operates normally.
